// File: rtl/pipe_pkg.sv
// Shared definitions for the flow-controlled inter-stage pipeline registers.
package pipe_pkg;

  // The state encoding doubles as the occupancy count of a stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Default control/data widths for each pipeline boundary.
  localparam int IF_ID_CTRL_W  = 1;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 6;
  localparam int ID_EX_DATA_W  = 137;
  localparam int EX_MEM_CTRL_W = 3;
  localparam int EX_MEM_DATA_W = 69;
  localparam int MEM_WB_CTRL_W = 1;
  localparam int MEM_WB_DATA_W = 68;

endpackage

// File: rtl/pipe_slot.sv
// One payload register (control + data) with load enable and synchronous clear.
module pipe_slot #(
  parameter int CTRL_W = 6,
  parameter int DATA_W = 137
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Payload register: clear wins over load so a flush never lets an entry in.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (clr_i) begin
      ctrl_q <= '0;
      data_q <= '0;
    end else if (load_i) begin
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with optional 2-entry skid buffer.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and an offered entry must be held until
// it is taken. flush discards everything held and drops any entry offered in
// the same cycle; a head taken in the flush cycle still counts as consumed.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t       state_q, state_d;
  logic              in_fire, out_fire;
  logic              head_load, skid_load;
  logic [CTRL_W-1:0] head_ctrl_d, head_ctrl, skid_ctrl;
  logic [DATA_W-1:0] head_data_d, head_data, skid_data;

  assign in_fire   = in_valid && in_ready && !flush;
  assign out_fire  = out_valid && out_ready;
  assign out_valid = (state_q != EMPTY);
  assign out_ctrl  = out_valid ? head_ctrl : '0;
  assign out_data  = head_data;
  assign occupancy = state_q;

  // State register; the state value is the occupancy seen on the debug port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state and slot loads. The head takes the new entry when the stage is
  // empty or draining at the same time; otherwise the entry parks in the skid
  // slot, which is promoted to the head when the head leaves.
  always_comb begin
    state_d     = state_q;
    head_load   = 1'b0;
    skid_load   = 1'b0;
    head_ctrl_d = in_ctrl;
    head_data_d = in_data;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d   = ONE;
          head_load = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          head_load = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          skid_load = 1'b1;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d     = ONE;
          head_load   = 1'b1;
          head_ctrl_d = skid_ctrl;
          head_data_d = skid_data;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      head_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_head (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (flush),
    .load_i(head_load),
    .ctrl_i(head_ctrl_d),
    .data_i(head_data_d),
    .ctrl_o(head_ctrl),
    .data_o(head_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (flush),
        .load_i(skid_load),
        .ctrl_i(in_ctrl),
        .data_i(in_data),
        .ctrl_o(skid_ctrl),
        .data_o(skid_data)
      );
      // Registered ready: decoded from state only, no path from out_ready.
      assign in_ready = (state_q != FULL);
    end else begin : g_noskid
      logic skid_load_unused;
      assign skid_load_unused = skid_load;
      assign skid_ctrl        = '0;
      assign skid_data        = '0;
      // Single slot: can accept when empty or when the head leaves this cycle.
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: dut_a is the skid-buffered stage, dut_b the single slot.
module tb_pipe_stage_reg;

  localparam int CW = 6;
  localparam int DW = 137;
  localparam int PW = CW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [CW-1:0] a_in_ctrl = '0, a_out_ctrl;
  logic [DW-1:0] a_in_data = '0, a_out_data;
  logic [1:0]    a_occ;
  logic          b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [CW-1:0] b_in_ctrl = '0, b_out_ctrl;
  logic [DW-1:0] b_in_data = '0, b_out_data;
  logic [1:0]    b_occ;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [PW-1:0] a_q[$];
  logic [PW-1:0] b_q[$];

  always @(negedge clk) begin : mon_a
    logic [PW-1:0] e;
    if (rst) begin
      a_q.delete();
    end else begin
      if (!a_out_valid) check("a_bubble_ctrl", a_out_ctrl, 0);
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) check("a_unexpected_out", 1, 0);
        else begin
          e = a_q.pop_front();
          check("a_out", {a_out_ctrl, a_out_data}, e);
        end
      end
      if (a_flush) a_q.delete();
      else if (a_in_valid && a_in_ready) a_q.push_back({a_in_ctrl, a_in_data});
    end
  end

  always @(negedge clk) begin : mon_b
    logic [PW-1:0] e;
    if (rst) begin
      b_q.delete();
    end else begin
      if (!b_out_valid) check("b_bubble_ctrl", b_out_ctrl, 0);
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) check("b_unexpected_out", 1, 0);
        else begin
          e = b_q.pop_front();
          check("b_out", {b_out_ctrl, b_out_data}, e);
        end
      end
      if (b_flush) b_q.delete();
      else if (b_in_valid && b_in_ready) b_q.push_back({b_in_ctrl, b_in_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry and hold it until accepted (bounded); returns stall cycles.
  task automatic send(input bit sel, input logic [CW-1:0] c, input logic [DW-1:0] d,
                      output int waited);
    bit ok;
    ok = 1'b0;
    if (sel) begin b_in_valid = 1; b_in_ctrl = c; b_in_data = d; end
    else     begin a_in_valid = 1; a_in_ctrl = c; a_in_data = d; end
    for (waited = 0; waited < 50; waited++) begin
      #1;
      ok = sel ? b_in_ready : a_in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (sel) b_in_valid = 0;
    else     a_in_valid = 0;
    if (!ok) check(sel ? "b_send_timeout" : "a_send_timeout", 0, 1);
  endtask

  task automatic drain(input bit sel);
    int k;
    if (sel) begin b_out_ready = 1; b_in_valid = 0; end
    else     begin a_out_ready = 1; a_in_valid = 0; end
    for (k = 0; k < 20; k++) begin
      if ((sel ? b_occ : a_occ) == 2'd0) break;
      tick();
    end
    check(sel ? "b_drain" : "a_drain", sel ? b_occ : a_occ, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int w;
    bit a_acc, b_acc;
    int seq;

    // Reset values, sampled while reset is held.
    #3;
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_ctrl",  a_out_ctrl, 0);
    check("rst_a_out_data",  a_out_data, 0);
    check("rst_a_occ",       a_occ, 0);
    check("rst_a_in_ready",  a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_in_ready",  b_in_ready, 1);
    @(posedge clk); @(posedge clk); #3;
    rst = 0;
    tick();
    check("post_rst_a_in_ready", a_in_ready, 1);

    // Single entry with one-cycle latency, then bubble.
    a_out_ready = 1;
    send(0, 6'h2A, 137'h1234, w);
    check("single_wait", w, 0);
    check("single_valid", a_out_valid, 1);
    check("single_ctrl", a_out_ctrl, 6'h2A);
    check("single_data", a_out_data, 137'h1234);
    tick();
    check("single_gone_valid", a_out_valid, 0);
    check("single_gone_ctrl", a_out_ctrl, 0);
    check("single_hold_data", a_out_data, 137'h1234);

    // Full-rate stream of 8 entries.
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) check("stream_valid", a_out_valid, 1);
      send(0, 6'($urandom_range(0, 63)), DW'(i), w);
      check("stream_no_stall", w, 0);
    end
    drain(0);

    // Backpressure on the skid stage.
    send(0, 6'h01, DW'(1), w);
    a_out_ready = 0;
    send(0, 6'h02, DW'(2), w);
    check("bp_skid_accept", w, 0);
    check("bp_occ_full", a_occ, 2);
    check("bp_in_ready_low", a_in_ready, 0);
    check("bp_head_data", a_out_data, DW'(1));
    a_in_valid = 1; a_in_ctrl = 6'h03; a_in_data = DW'(3);
    tick();
    check("bp_still_full", a_occ, 2);
    check("bp_still_blocked", a_in_ready, 0);
    a_out_ready = 1;
    send(0, 6'h03, DW'(3), w);
    send(0, 6'h04, DW'(4), w);
    drain(0);

    // Backpressure on the single-slot stage.
    b_out_ready = 1;
    send(1, 6'h15, DW'(21), w);
    b_out_ready = 0;
    b_in_valid = 1; b_in_ctrl = 6'h16; b_in_data = DW'(22);
    #1;
    check("b_ready_low_same_cycle", b_in_ready, 0);
    b_out_ready = 1;
    #1;
    check("b_ready_follows", b_in_ready, 1);
    tick();
    b_in_valid = 0;
    check("b_replace_occ", b_occ, 1);
    check("b_replace_data", b_out_data, DW'(22));
    check("b_replace_ctrl", b_out_ctrl, 6'h16);
    drain(1);

    // Flush from FULL with an entry offered in the same cycle.
    a_out_ready = 0;
    send(0, 6'h05, DW'(5), w);
    send(0, 6'h06, DW'(6), w);
    check("flush_pre_full", a_occ, 2);
    a_in_valid = 1; a_in_ctrl = 6'h07; a_in_data = DW'(7);
    a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0;
    check("flush_valid", a_out_valid, 0);
    check("flush_ctrl", a_out_ctrl, 0);
    check("flush_data", a_out_data, 0);
    check("flush_occ", a_occ, 0);
    check("flush_in_ready", a_in_ready, 1);

    // Flush from ONE: the offered entry is dropped even though in_ready is 1.
    send(0, 6'h08, DW'(8), w);
    a_in_valid = 1; a_in_ctrl = 6'h09; a_in_data = DW'(9);
    a_flush = 1;
    #1;
    check("flush_one_in_ready", a_in_ready, 1);
    tick();
    a_flush = 0; a_in_valid = 0;
    check("flush_one_occ", a_occ, 0);
    a_out_ready = 1;
    tick(); tick();
    check("flush_one_no_ghost", a_out_valid, 0);

    // Asynchronous reset between edges while FULL.
    a_out_ready = 0;
    send(0, 6'h0A, DW'(10), w);
    send(0, 6'h0B, DW'(11), w);
    check("arst_pre_full", a_occ, 2);
    #2;
    rst = 1;
    #1;
    check("arst_valid", a_out_valid, 0);
    check("arst_ctrl", a_out_ctrl, 0);
    check("arst_data", a_out_data, 0);
    check("arst_occ", a_occ, 0);
    @(posedge clk); #2;
    rst = 0;
    tick();
    a_out_ready = 1;
    send(0, 6'h0C, DW'(12), w);
    check("arst_after_valid", a_out_valid, 1);
    check("arst_after_data", a_out_data, DW'(12));
    drain(0);

    // Random traffic and backpressure on both stages.
    a_acc = 0; b_acc = 0; seq = 100;
    for (int c = 0; c < 120; c++) begin
      if (!a_in_valid || a_acc) begin
        a_in_valid = 1'($urandom_range(0, 1));
        a_in_ctrl  = 6'($urandom_range(0, 63));
        a_in_data  = {$urandom(), 105'(seq)};
        seq++;
      end
      if (!b_in_valid || b_acc) begin
        b_in_valid = 1'($urandom_range(0, 1));
        b_in_ctrl  = 6'($urandom_range(0, 63));
        b_in_data  = {$urandom(), 105'(seq)};
        seq++;
      end
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      a_acc = a_in_valid && a_in_ready;
      b_acc = b_in_valid && b_in_ready;
      @(posedge clk);
      #1;
    end
    a_in_valid = 0;
    b_in_valid = 0;
    drain(0);
    drain(1);
    tick();
    check("a_queue_empty", a_q.size(), 0);
    check("b_queue_empty", b_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, flow-controlled pipeline stage register that replaces the fixed-field, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload split into a control field and a data field. It adds a valid/ready handshake so stages can stall, an optional 2-entry skid buffer so `in_ready` is fully registered, and flush semantics that turn the stage into a bubble with zeroed control bits.

## Interface
- `CTRL_W`, default 6: width of the control field (wb_en, mem_rd, mem_wr, B, S, imm, …). Forced to zero on bubble, flush and reset.
- `DATA_W`, default 137: width of the data field (PC, operand values, Rd, shift operand, imm24, carry, exec_cmd).
- `SKID`, default 1:
  - 1 = 2-entry skid buffer with registered `in_ready`.
  - 0 = single entry with combinational `in_ready`.
- `clk` input, 1 bit: clock. All state is updated on the rising edge.
- `rst` input, 1 bit: reset. Asynchronous and active-high.
- `flush` input, 1 bit: synchronous discard of all held entries. Has priority over every transfer.
- `in_valid` input, 1 bit: upstream offers an entry.
- `in_ready` output, 1 bit: stage can accept an entry this cycle.
- `in_ctrl` input, CTRL_W bits: control field of the offered entry.
- `in_data` input, DATA_W bits: data field of the offered entry.
- `out_valid` output, 1 bit: head entry is valid.
- `out_ready` input, 1 bit: downstream consumes the head entry.
- `out_ctrl` output, CTRL_W bits: head control field. Equals 0 whenever `out_valid` = 0.
- `out_data` output, DATA_W bits: head data field. Holds its last value when the stage is empty.
- `occupancy` output, 2 bits: number of held entries (0..2; max 1 when SKID = 0).

## Operation
- A transfer in occurs when `in_valid && in_ready`. A transfer out occurs when `out_valid && out_ready`.
- Entries leave in strict FIFO order; the payload is never modified in flight.
- SKID = 1 state machine (state register holds occupancy):
  - **EMPTY**, in → **ONE**.
  - **ONE**, in only → **FULL** (entry goes to the skid slot).
  - **ONE**, out only → **EMPTY**.
  - **ONE**, in and out together → **ONE** (head replaced by the new entry).
  - **FULL**, out → **ONE** (skid slot moves to head). No transfer in is possible from FULL.
  - `in_ready = (state != FULL)`, decoded from the state register only; no combinational path from `out_ready`.
- SKID = 0:
  - Single slot; `in_ready = !out_valid || out_ready`.
  - Simultaneous in and out replaces the slot.
- `out_valid = (state != EMPTY)`.
- `out_ctrl = out_valid ? head_ctrl : 0`.
- Flush:
  - Next state is EMPTY, both slots' control fields are cleared, and data fields are cleared to 0.
  - An entry offered in the flush cycle is dropped, even though `in_ready` may be 1.
  - A head consumed in the flush cycle still counts as consumed by downstream.
- Reset clears both slots, control and data. State goes to EMPTY.

## Timing
- Reset values: `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0, `occupancy` = 0. `in_ready` = 1 while in and after reset.
- Latency: an entry accepted at edge N appears on `out_*` after edge N, i.e. one cycle, in both modes.
- Throughput: 1 entry/cycle when `out_ready` is held high.
- Backpressure:
  - SKID = 1: after `out_ready` falls, at most one extra entry is accepted. `in_ready` drops the cycle after the stage reaches FULL.
  - SKID = 0: `in_ready` follows `out_ready` in the same cycle.
- Flush takes effect at the next edge. `out_valid` = 0 in the following cycle; `in_ready` = 1 in the following cycle.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously); no partial entry survives.
- When `out_ready` = 1 while EMPTY, there is no effect.

## Structure
- Shared package `pipe_pkg`:
  - state enum `pipe_state_t` {EMPTY, ONE, FULL}.
  - Default width constants for each pipeline boundary, e.g. `ID_EX_CTRL_W` = 6, `ID_EX_DATA_W` = 137.
- Sub-module `pipe_slot`: one payload register with load enable and synchronous clear. Instantiated once (SKID = 0) or twice (head plus skid, SKID = 1).

## Test plan
- **Reset then single entry:** reset; then `in_valid`=1, ctrl=6'h2A, data=0x1234 for one cycle with `out_ready`=1 → next cycle `out_valid`=1, `out_ctrl`=6'h2A, `out_data`=0x1234; cycle after that `out_valid`=0, `out_ctrl`=0.
- **Full-rate stream:** 8 entries back-to-back (data 1..8), `out_ready`=1 throughout → outputs 1..8 on consecutive cycles, `in_ready` never 0.
- **Backpressure, SKID=1:**
  - Stream entries 1..4 and drop `out_ready` while entry 1 is at the head.
  - Required: entry 2 is accepted into the skid slot, `occupancy`=2, `in_ready`=0 from the next cycle.
  - Raise `out_ready` → outputs 1, 2, 3, 4 in order, none lost or duplicated.
- **Backpressure, SKID=0:** `out_ready`=0 with 1 entry held → `in_ready`=0 in the same cycle. Raise `out_ready` with `in_valid`=1 → replacement occurs and `occupancy` stays 1.
- **Flush:**
  - With FULL (entries 5, 6), assert `flush` together with `in_valid` (entry 7).
  - Required next cycle: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `occupancy`=0, `in_ready`=1. Entry 7 never appears.
- **Asynchronous reset mid-operation:** assert `rst` between clock edges with `occupancy`=2 → `out_valid`, `out_ctrl`, `out_data` go to 0 immediately. After release, the first accepted entry appears with 1-cycle latency.
